// File: rtl/ps2_scancode_fsm_pkg.sv
// Shared definitions for the PS/2 scan-code consumer: FSM encoding, protocol bytes, defaults.
package kbd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [7:0] BREAK_CODE_DEF = 8'hF0;
  localparam logic [7:0] EXT_CODE_DEF   = 8'hE0;
  localparam logic [7:0] ERR_CODE_LO    = 8'h00;
  localparam logic [7:0] ERR_CODE_HI    = 8'hFF;
  localparam int         COUNT_MOD_DEF  = 100;

endpackage

// File: rtl/ps2_scancode_fsm_if.sv
// Byte handshake between the ps2_keyboard FIFO (master) and the scan-code consumer (slave).
interface ps2_scancode_fsm_if;
  // ps2_ready acts as valid: while high, ps2_byte is the stable FIFO head. The consumer pops it by
  // driving nextdata_n low for exactly one cycle; the head and ready refresh in the following cycle.
  logic [7:0] ps2_byte;
  logic       ps2_ready;
  logic       ps2_overflow;
  logic       nextdata_n;

  modport master (output ps2_byte, output ps2_ready, output ps2_overflow, input nextdata_n);
  modport slave  (input ps2_byte, input ps2_ready, input ps2_overflow, output nextdata_n);
endinterface

// File: rtl/ps2_scancode_fsm_ascii_lut.sv
// Set-2 scan code to upper-case ASCII table (letters, digits, space). Built only with KBD_ASCII_EN.
`ifdef KBD_ASCII_EN
module ps2_ascii_lut (
  input  logic [7:0] key_code,
  output logic [7:0] ascii
);
  always_comb begin
    ascii = 8'h00;
    case (key_code)
      8'h1C: ascii = 8'h41; 8'h32: ascii = 8'h42; 8'h21: ascii = 8'h43; 8'h23: ascii = 8'h44;
      8'h24: ascii = 8'h45; 8'h2B: ascii = 8'h46; 8'h34: ascii = 8'h47; 8'h33: ascii = 8'h48;
      8'h43: ascii = 8'h49; 8'h3B: ascii = 8'h4A; 8'h42: ascii = 8'h4B; 8'h4B: ascii = 8'h4C;
      8'h3A: ascii = 8'h4D; 8'h31: ascii = 8'h4E; 8'h44: ascii = 8'h4F; 8'h4D: ascii = 8'h50;
      8'h15: ascii = 8'h51; 8'h2D: ascii = 8'h52; 8'h1B: ascii = 8'h53; 8'h2C: ascii = 8'h54;
      8'h3C: ascii = 8'h55; 8'h2A: ascii = 8'h56; 8'h1D: ascii = 8'h57; 8'h22: ascii = 8'h58;
      8'h35: ascii = 8'h59; 8'h1A: ascii = 8'h5A;
      8'h45: ascii = 8'h30; 8'h16: ascii = 8'h31; 8'h1E: ascii = 8'h32; 8'h26: ascii = 8'h33;
      8'h25: ascii = 8'h34; 8'h2E: ascii = 8'h35; 8'h36: ascii = 8'h36; 8'h3D: ascii = 8'h37;
      8'h3E: ascii = 8'h38; 8'h46: ascii = 8'h39;
      8'h29: ascii = 8'h20;
      default: ascii = 8'h00;
    endcase
  end
endmodule
`endif

// File: rtl/ps2_scancode_fsm.sv
// Pops PS/2 set-2 bytes from the keyboard FIFO, decodes make/break/extended sequences, tracks the
// held key and counts presses. Define KBD_ASCII_EN to register an ASCII translation of key_code.
module ps2_scancode_fsm
  import kbd_pkg::*;
#(
  parameter int         COUNT_MOD  = COUNT_MOD_DEF,
  parameter logic [7:0] BREAK_CODE = BREAK_CODE_DEF,
  parameter logic [7:0] EXT_CODE   = EXT_CODE_DEF
) (
  input  logic               clk,
  input  logic               resetn,
  ps2_scancode_fsm_if.slave  ps2,
  output logic [7:0]         key_code,
  output logic               key_ext,
  output logic               key_down,
  output logic               key_valid,
  output logic               key_make,
  output logic [7:0]         press_count,
  output logic [7:0]         ascii,
  output logic               code_err,
  output logic               ovf_flag,
  output state_t             dbg_state
);

  localparam logic [7:0] CNT_MAX = 8'(COUNT_MOD - 1);

  state_t     state, state_nxt;
  logic [7:0] byte_q, byte_q_nxt;
  logic       ext_pending, ext_nxt, brk_pending, brk_nxt;
  // The held key is kept apart from key_code: a break for another key updates key_code only.
  logic [7:0] held_code, held_code_nxt;
  logic       held_ext, held_ext_nxt;
  logic [7:0] code_nxt, count_nxt;
  logic       kext_nxt, down_nxt, make_nxt, valid_nxt, err_nxt;
  logic       same_held;

  assign same_held = key_down && (held_code == byte_q) && (held_ext == ext_pending);
  assign dbg_state = state;

  always_comb begin
    state_nxt     = state;
    byte_q_nxt    = byte_q;
    ext_nxt       = ext_pending;
    brk_nxt       = brk_pending;
    held_code_nxt = held_code;
    held_ext_nxt  = held_ext;
    code_nxt      = key_code;
    kext_nxt      = key_ext;
    down_nxt      = key_down;
    make_nxt      = key_make;
    count_nxt     = press_count;
    valid_nxt     = 1'b0;
    err_nxt       = 1'b0;
    unique case (state)
      IDLE: begin
        if (ps2.ps2_ready) begin
          byte_q_nxt = ps2.ps2_byte;
          state_nxt  = POP;
        end
      end
      POP: begin
        state_nxt = WAIT;
        if (byte_q == EXT_CODE) begin
          ext_nxt = 1'b1;
        end else if (byte_q == BREAK_CODE) begin
          brk_nxt = 1'b1;
        end else begin
          ext_nxt = 1'b0;
          brk_nxt = 1'b0;
          if (byte_q == ERR_CODE_LO || byte_q == ERR_CODE_HI) begin
            err_nxt = 1'b1;
          end else if (brk_pending) begin
            valid_nxt = 1'b1;
            make_nxt  = 1'b0;
            code_nxt  = byte_q;
            kext_nxt  = ext_pending;
            if (same_held) down_nxt = 1'b0;
          end else if (same_held) begin
            // Typematic repeat of the held key: refresh the code, no event.
            code_nxt = byte_q;
            kext_nxt = ext_pending;
          end else begin
            valid_nxt     = 1'b1;
            make_nxt      = 1'b1;
            down_nxt      = 1'b1;
            code_nxt      = byte_q;
            kext_nxt      = ext_pending;
            held_code_nxt = byte_q;
            held_ext_nxt  = ext_pending;
            count_nxt     = (press_count == CNT_MAX) ? 8'd0 : press_count + 8'd1;
          end
        end
      end
      WAIT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      byte_q         <= 8'h00;
      ext_pending    <= 1'b0;
      brk_pending    <= 1'b0;
      held_code      <= 8'h00;
      held_ext       <= 1'b0;
      ps2.nextdata_n <= 1'b1;
      key_code       <= 8'h00;
      key_ext        <= 1'b0;
      key_down       <= 1'b0;
      key_valid      <= 1'b0;
      key_make       <= 1'b0;
      press_count    <= 8'h00;
      code_err       <= 1'b0;
      ovf_flag       <= 1'b0;
    end else begin
      state          <= state_nxt;
      byte_q         <= byte_q_nxt;
      ext_pending    <= ext_nxt;
      brk_pending    <= brk_nxt;
      held_code      <= held_code_nxt;
      held_ext       <= held_ext_nxt;
      ps2.nextdata_n <= (state_nxt != POP);
      key_code       <= code_nxt;
      key_ext        <= kext_nxt;
      key_down       <= down_nxt;
      key_valid      <= valid_nxt;
      key_make       <= make_nxt;
      press_count    <= count_nxt;
      code_err       <= err_nxt;
      ovf_flag       <= ovf_flag | ps2.ps2_overflow;
    end
  end

`ifdef KBD_ASCII_EN
  logic [7:0] ascii_nxt;

  ps2_ascii_lut u_ascii_lut (
    .key_code (code_nxt),
    .ascii    (ascii_nxt)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ascii <= 8'h00;
    else         ascii <= ascii_nxt;
  end
`else
  assign ascii = 8'h00;
`endif

endmodule

// File: tb/tb_ps2_scancode_fsm.sv
// Bench for ps2_scancode_fsm: FIFO emulation, directed scenarios, then random byte streams
// checked against a transaction-level keyboard model.
module tb_ps2_scancode_fsm;
  import kbd_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  ps2_scancode_fsm_if ps2 ();

  logic [7:0] key_code, press_count, ascii;
  logic       key_ext, key_down, key_valid, key_make, code_err, ovf_flag;
  state_t     dbg_state;

  ps2_scancode_fsm dut (
    .clk         (clk),
    .resetn      (resetn),
    .ps2         (ps2.slave),
    .key_code    (key_code),
    .key_ext     (key_ext),
    .key_down    (key_down),
    .key_valid   (key_valid),
    .key_make    (key_make),
    .press_count (press_count),
    .ascii       (ascii),
    .code_err    (code_err),
    .ovf_flag    (ovf_flag),
    .dbg_state   (dbg_state)
  );

  int tests = 0;
  int fails = 0;

  // bench FIFO and scoreboard: exp_q holds bytes popped by the DUT awaiting their decode
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int cyc = 0, last_pop = 0, pops = 0, pushes = 0;
  logic pop_backlog = 1'b0;
  logic ovf_req = 1'b0, ovf_sent = 1'b0;
  int obs_makes = 0, obs_errs = 0;

  // keyboard model state
  logic       m_ext, m_brk, m_held, m_hext, m_kext, m_make, m_ovf;
  logic [7:0] m_hcode, m_code;
  int         m_count;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] ascii_of(input logic [7:0] c);
`ifdef KBD_ASCII_EN
    logic [7:0] codes [37] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                               8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                               8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A,
                               8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E,
                               8'h46, 8'h29};
    string chars = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789 ";
    for (int i = 0; i < 37; i++) if (codes[i] == c) return chars[i];
    return 8'h00;
`else
    return 8'h00;
`endif
  endfunction

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_held = 0; m_hext = 0; m_kext = 0; m_make = 0; m_ovf = 0;
    m_hcode = 8'h00; m_code = 8'h00; m_count = 0;
  endtask

  // One consumed byte, following the key-event rules of the keyboard protocol.
  task automatic model_apply(input logic [7:0] b, output logic v, output logic e);
    logic same;
    v = 0; e = 0;
    same = m_held && (m_hcode == b) && (m_hext == m_ext);
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      if (b == 8'h00 || b == 8'hFF) e = 1;
      else if (m_brk) begin
        v = 1; m_make = 0; m_code = b; m_kext = m_ext;
        if (same) m_held = 0;
      end else if (same) begin
        m_code = b; m_kext = m_ext;
      end else begin
        v = 1; m_make = 1; m_held = 1; m_hcode = b; m_hext = m_ext;
        m_code = b; m_kext = m_ext; m_count = (m_count + 1) % 100;
      end
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    pushes++;
  endtask

  // One cycle: observe and check at the falling edge, emulate the FIFO, drive inputs.
  task automatic tick();
    logic [7:0] b;
    logic e_valid, e_err;
    e_valid = 0; e_err = 0;
    @(negedge clk);
    cyc++;
    if (!resetn) begin
      model_reset();
      pushes -= fifo_q.size();
      fifo_q.delete();
      exp_q.delete();
      pop_backlog = 0;
    end else begin
      if (exp_q.size() > 0) begin
        b = exp_q.pop_front();
        model_apply(b, e_valid, e_err);
      end
      if (ovf_sent) m_ovf = 1;
    end
    if (key_valid && key_make) obs_makes++;
    if (code_err) obs_errs++;
    chk("key_valid", 32'(key_valid), 32'(e_valid));
    chk("code_err", 32'(code_err), 32'(e_err));
    chk("key_code", 32'(key_code), 32'(m_code));
    chk("key_ext", 32'(key_ext), 32'(m_kext));
    chk("key_down", 32'(key_down), 32'(m_held));
    chk("press_count", 32'(press_count), 32'(m_count));
    chk("ovf_flag", 32'(ovf_flag), 32'(m_ovf));
    chk("ascii", 32'(ascii), 32'(ascii_of(m_code)));
    if (e_valid) chk("key_make", 32'(key_make), 32'(m_make));
    if (!resetn) chk("nextdata_n_reset", 32'(ps2.nextdata_n), 32'd1);
    else if (ps2.nextdata_n == 1'b0) begin
      chk("pop_nonempty", 32'(fifo_q.size() > 0), 32'd1);
      if (fifo_q.size() > 0) begin
        if (pop_backlog) chk("pop_spacing", 32'(cyc - last_pop), 32'd3);
        last_pop = cyc;
        exp_q.push_back(fifo_q.pop_front());
        pops++;
        pop_backlog = (fifo_q.size() > 0);
      end
    end
    ps2.ps2_ready    = (fifo_q.size() > 0);
    ps2.ps2_byte     = (fifo_q.size() > 0) ? fifo_q[0] : 8'($urandom);
    ps2.ps2_overflow = ovf_req;
    ovf_sent         = ovf_req;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((fifo_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_timeout", 32'(n < budget), 32'd1);
    tick();
    tick();
  endtask

  function automatic logic [7:0] rand_byte();
    logic [7:0] pool [6] = '{8'h1C, 8'h32, 8'h75, 8'h16, 8'h29, 8'h45};
    case ($urandom_range(0, 9))
      0, 1:    return 8'hE0;
      2, 3:    return 8'hF0;
      4:       return ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
      5:       return 8'($urandom_range(1, 254));
      default: return pool[$urandom_range(0, 5)];
    endcase
  endfunction

  initial begin
    int p0, mk0, er0;
    ps2.ps2_byte = 8'h00; ps2.ps2_ready = 1'b0; ps2.ps2_overflow = 1'b0;
    model_reset();

    // reset state
    repeat (3) tick();
    chk("reset_state", 32'(dbg_state), 32'(IDLE));
    resetn = 1'b1;
    tick();
    chk("idle_after_release", 32'(dbg_state), 32'(IDLE));

    // make / break of A
    push(8'h1C); push(8'hF0); push(8'h1C);
    drain(200);
    chk("t2_count", 32'(press_count), 32'd1);
    chk("t2_down", 32'(key_down), 32'd0);
    chk("t2_code", 32'(key_code), 32'h1C);

    // extended make / break
    p0 = pops;
    push(8'hE0); push(8'h75); push(8'hE0); push(8'hF0); push(8'h75);
    drain(200);
    chk("t3_pops", 32'(pops - p0), 32'd5);
    chk("t3_ext", 32'(key_ext), 32'd1);
    chk("t3_count", 32'(press_count), 32'd2);

    // typematic repeat gives one make only
    mk0 = obs_makes;
    push(8'h1C); push(8'h1C); push(8'h1C);
    drain(200);
    chk("t4_held", 32'(key_down), 32'd1);
    push(8'hF0); push(8'h1C);
    drain(200);
    chk("t4_makes", 32'(obs_makes - mk0), 32'd1);
    chk("t4_released", 32'(key_down), 32'd0);
    chk("t4_count", 32'(press_count), 32'd3);

    // counter wrap and error byte
    for (int i = 0; i < 96; i++) push((i % 2 == 0) ? 8'h32 : 8'h1C);
    drain(2000);
    chk("t5_count99", 32'(press_count), 32'd99);
    push(8'h16);
    drain(200);
    chk("t5_wrap", 32'(press_count), 32'd0);
    er0 = obs_errs;
    push(8'hFF);
    drain(200);
    chk("t5_err", 32'(obs_errs - er0), 32'd1);
    chk("t5_count_hold", 32'(press_count), 32'd0);

    // overflow is sticky
    ovf_req = 1'b1;
    tick();
    ovf_req = 1'b0;
    repeat (5) tick();
    chk("t6_ovf", 32'(ovf_flag), 32'd1);

    // reset in the middle of a stream
    push(8'hE0); push(8'h1C); push(8'h32); push(8'hF0); push(8'h32); push(8'h29);
    repeat (4) tick();
    resetn = 1'b0;
    repeat (3) tick();
    chk("t1_ovf_cleared", 32'(ovf_flag), 32'd0);
    chk("t1_count_cleared", 32'(press_count), 32'd0);
    resetn = 1'b1;
    tick();
    chk("t1_idle", 32'(dbg_state), 32'(IDLE));
    push(8'h1C);
    drain(200);
    chk("t1_restart_count", 32'(press_count), 32'd1);

    // random streams with random idle gaps
    for (int i = 0; i < 400; i++) begin
      int nb;
      nb = $urandom_range(0, 3);
      for (int k = 0; k < nb; k++) push(rand_byte());
      repeat ($urandom_range(1, 4)) tick();
    end
    drain(5000);

    chk("all_popped", 32'(pops), 32'(pushes));
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
